pacman_graphics: RTL and testbench

Per-pixel colour generator for the Pac-Man VGA display. It takes the running 640×480 VGA raster counters and the Pac-Man position, and emits one registered 8-bit RGB332 colour per clock. It sits between the game-logic block, which supplies positions, and the VGA timing/DAC stage, which consumes the colour. It draws the maze walls, the background and an animated Pac-Man disc.

---
 rtl/pacman_gfx_pkg.sv | 61 ++++++
 rtl/pacman_sprite.sv | 41 ++++
 rtl/pacman_graphics.sv | 141 ++++++++++++++
 tb/tb_pacman_graphics.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/pacman_gfx_pkg.sv
// pacman_gfx_pkg
//   Shared constants for the Pac-Man pixel pipeline: VGA raster geometry,
//   playfield geometry, the Pac-Man radius, the RGB332 palette and the
//   28x31 maze ROM (1 = wall). MAZE[row][col] reads the maze as printed:
//   row 0 is the top row, col 0 is the left-most column.
package pacman_gfx_pkg;

    // Raster geometry (11 bits so raster maths never overflows a 10-bit counter)
    localparam logic [10:0] H_VISIBLE = 11'd640;
    localparam logic [10:0] V_VISIBLE = 11'd480;
    localparam logic [10:0] H_TOTAL   = 11'd800;
    localparam logic [10:0] V_TOTAL   = 11'd525;

    // Playfield geometry
    localparam int          MAZE_COLS = 28;
    localparam int          MAZE_ROWS = 31;
    localparam int          TILE      = 8;
    localparam logic [10:0] PF_W      = 11'(MAZE_COLS * TILE);   // 224
    localparam logic [10:0] PF_H      = 11'(MAZE_ROWS * TILE);   // 248

    // Squared radius of the Pac-Man disc
    localparam int unsigned PACMAN_R2 = 42;

    // RGB332 palette {R[2:0], G[2:0], B[1:0]}
    localparam logic [7:0] COL_BLACK  = 8'h00;
    localparam logic [7:0] COL_WALL   = 8'h03;
    localparam logic [7:0] COL_PACMAN = 8'hFC;
    localparam logic [7:0] COL_GRID   = 8'hFF;

    typedef logic [0:MAZE_COLS-1] maze_row_t;

    // Distinct maze rows; the ghost-house door is drawn as path.
    localparam maze_row_t R_EDGE  = 28'b1111_1111_1111_1111_1111_1111_1111;
    localparam maze_row_t R_TOP   = 28'b1_000000000000_11_000000000000_1;
    localparam maze_row_t R_BLOCK = 28'b1_0_1111_0_11111_0_11_0_11111_0_1111_0_1;
    localparam maze_row_t R_OPEN  = 28'b1_0000000000000_0000000000000_1;
    localparam maze_row_t R_TBAR  = 28'b1_0_1111_0_11_0_11111111_0_11_0_1111_0_1;
    localparam maze_row_t R_GAPS  = 28'b1_000000_11_0000_11_0000_11_000000_1;
    localparam maze_row_t R_SIDE  = 28'b111111_0_11111_0_11_0_11111_0_111111;
    localparam maze_row_t R_LANE  = 28'b111111_0_11_0000000000_11_0_111111;
    localparam maze_row_t R_DOOR  = 28'b111111_0_11_0_111_00_111_0_11_0_111111;
    localparam maze_row_t R_HOUSE = 28'b111111_0_11_0_1_000000_1_0_11_0_111111;
    localparam maze_row_t R_TUNL  = 28'b0000000000_1_000000_1_0000000000;
    localparam maze_row_t R_BAR   = 28'b111111_0_11_0_11111111_0_11_0_111111;
    localparam maze_row_t R_START = 28'b1_000_11_0000000000000000_11_000_1;
    localparam maze_row_t R_NOTCH = 28'b111_0_11_0_11_0_11111111_0_11_0_11_0_111;
    localparam maze_row_t R_LONG  = 28'b1_0_1111111111_0_11_0_1111111111_0_1;

    localparam logic [0:MAZE_ROWS-1][0:MAZE_COLS-1] MAZE = {
        R_EDGE,  R_TOP,   R_BLOCK, R_BLOCK, R_BLOCK, R_OPEN,  R_TBAR,  R_TBAR,   // 0-7
        R_GAPS,  R_SIDE,  R_SIDE,  R_LANE,  R_DOOR,  R_HOUSE, R_TUNL,  R_HOUSE,  // 8-15
        R_BAR,   R_LANE,  R_BAR,   R_BAR,   R_TOP,   R_BLOCK, R_BLOCK, R_START,  // 16-23
        R_NOTCH, R_NOTCH, R_GAPS,  R_LONG,  R_LONG,  R_OPEN,  R_EDGE             // 24-30
    };

    // Wall lookup by tile index. Callers only pass rows 0-30 and cols 0-27.
    function automatic logic is_wall(input logic [4:0] col, input logic [4:0] row);
        return MAZE[row][col];
    endfunction

endpackage

// File: rtl/pacman_sprite.sv
// pacman_sprite
//   Combinational hit test for the Pac-Man disc with a right-facing mouth.
//   Ports:
//     dx, dy     : signed pixel offset from the Pac-Man centre (11 bits)
//     mouth_open : 1 removes the wedge dx > 0, |dy| <= dx
//     hit        : 1 when the pixel belongs to Pac-Man
module pacman_sprite
    import pacman_gfx_pkg::*;
(
    input  logic signed [10:0] dx,
    input  logic signed [10:0] dy,
    input  logic               mouth_open,
    output logic               hit
);

    logic signed [21:0] dx_w;
    logic signed [21:0] dy_w;
    logic        [21:0] dx2;
    logic        [21:0] dy2;
    logic        [22:0] r2;
    logic        [11:0] dy_abs;
    logic               in_disc;
    logic               in_wedge;

    // Squares of |d| <= 1024 fit in 21 bits, so the 22-bit signed product
    // is always non-negative and can be read as unsigned.
    assign dx_w = {{11{dx[10]}}, dx};
    assign dy_w = {{11{dy[10]}}, dy};
    assign dx2  = dx_w * dx_w;
    assign dy2  = dy_w * dy_w;
    assign r2   = {1'b0, dx2} + {1'b0, dy2};

    assign in_disc = (r2 <= 23'(PACMAN_R2));

    // 12-bit magnitude so that dy = -1024 cannot overflow.
    assign dy_abs   = dy[10] ? (12'd0 - {dy[10], dy}) : {1'b0, dy};
    assign in_wedge = !dx[10] && (dx != 11'sd0) && (dy_abs <= {1'b0, dx});

    assign hit = in_disc && !(mouth_open && in_wedge);

endmodule

// File: rtl/pacman_graphics.sv
// pacman_graphics
//   Per-pixel RGB332 colour generator for the 640x480 Pac-Man display.
//   Draws the maze, the background and an animated Pac-Man, one registered
//   colour per pixel clock (one-cycle latency from hc/vc to vga_data).
//   Ports:
//     clk                      : pixel clock
//     rst                      : asynchronous active-low reset
//     btn                      : active-low pause of the mouth animation
//     hc, vc                   : raster counters (0-799, 0-524)
//     switches                 : debug controls (GRAPHICS_DEBUG_EN builds only)
//     pacman_xloc, pacman_yloc : Pac-Man centre in playfield pixels
//     bg_color                 : colour of non-wall playfield pixels
//     vga_data                 : registered RGB332 pixel colour
//   Build option GRAPHICS_DEBUG_EN:
//     switches[0] : test pattern {hc[7:5], vc[7:5], hc[4:3]} on visible pixels
//     switches[1] : tile-grid lines in white, above walls and below Pac-Man
module pacman_graphics
    import pacman_gfx_pkg::*;
#(
    parameter int PF_X0 = 208,
    parameter int PF_Y0 = 116
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic [9:0] hc,
    input  logic [9:0] vc,
    input  logic [9:0] switches,
    input  logic [8:0] pacman_xloc,
    input  logic [8:0] pacman_yloc,
    input  logic [7:0] bg_color,
    output logic [7:0] vga_data
);

    localparam logic [10:0] PF_X0_W = 11'(PF_X0);
    localparam logic [10:0] PF_Y0_W = 11'(PF_Y0);

    logic [10:0]        hc_w;
    logic [10:0]        vc_w;
    logic [10:0]        px_full;
    logic [10:0]        py_full;
    logic [7:0]         px;
    logic [7:0]         py;
    logic               visible;
    logic               in_pf;
    logic               wall;
    logic [10:0]        pac_cx;
    logic [10:0]        pac_cy;
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic [3:0]         frame_cnt;
    logic               mouth_open;
    logic               frame_end;
    logic               pac_hit;
    logic [7:0]         pix_color;

    assign hc_w = {1'b0, hc};
    assign vc_w = {1'b0, vc};

    // Anything at or beyond the visible edge, including out-of-range
    // counter values, is blanking.
    assign visible = (hc_w < H_VISIBLE) && (vc_w < V_VISIBLE);

    // Playfield coordinates; only the low 8 bits matter once in_pf holds.
    assign px_full = hc_w - PF_X0_W;
    assign py_full = vc_w - PF_Y0_W;
    assign px      = px_full[7:0];
    assign py      = py_full[7:0];
    assign in_pf   = (hc_w >= PF_X0_W) && (px_full < PF_W) &&
                     (vc_w >= PF_Y0_W) && (py_full < PF_H);

    assign wall = is_wall(px[7:3], py[7:3]);

    // Offsets from the Pac-Man centre, in screen space.
    assign pac_cx = PF_X0_W + {2'b00, pacman_xloc};
    assign pac_cy = PF_Y0_W + {2'b00, pacman_yloc};
    assign dx     = hc_w - pac_cx;
    assign dy     = vc_w - pac_cy;

    assign mouth_open = frame_cnt[3];
    assign frame_end  = (hc_w == H_TOTAL - 11'd1) && (vc_w == V_TOTAL - 11'd1);

    pacman_sprite u_sprite (
        .dx         (dx),
        .dy         (dy),
        .mouth_open (mouth_open),
        .hit        (pac_hit)
    );

    // Colour priority: blanking, [debug pattern], outside playfield,
    // Pac-Man, [debug grid], wall, background.
    // NOTE: pix_color is given a default before the if-chain so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        pix_color = bg_color;
        if (!visible) begin
            pix_color = COL_BLACK;
        end
`ifdef GRAPHICS_DEBUG_EN
        else if (switches[0]) begin
            pix_color = {hc[7:5], vc[7:5], hc[4:3]};
        end
`endif
        else if (!in_pf) begin
            pix_color = COL_BLACK;
        end else if (pac_hit) begin
            pix_color = COL_PACMAN;
        end
`ifdef GRAPHICS_DEBUG_EN
        else if (switches[1] && ((px[2:0] == 3'd0) || (py[2:0] == 3'd0))) begin
            pix_color = COL_GRID;
        end
`endif
        else if (wall) begin
            pix_color = COL_WALL;
        end
    end

`ifdef GRAPHICS_DEBUG_EN
    logic unused_debug;
    assign unused_debug = ^switches[9:2];
`else
    logic unused_debug;
    assign unused_debug = ^{switches, px[2:0], py[2:0]};
`endif

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga_data  <= COL_BLACK;
            frame_cnt <= 4'd0;
        end else begin
            vga_data <= pix_color;
            if (frame_end && btn) begin
                frame_cnt <= frame_cnt + 4'd1;   // wraps 15 -> 0
            end
        end
    end

endmodule

// File: tb/tb_pacman_graphics.sv
// tb_pacman_graphics
//   Directed self-checking bench for pacman_graphics. Raster counters are
//   driven directly; a frame boundary is one clock at (799,524).
module tb_pacman_graphics;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b1;
    logic [9:0] hc = '0;
    logic [9:0] vc = '0;
    logic [9:0] switches = '0;
    logic [8:0] pacman_xloc = 9'd120;
    logic [8:0] pacman_yloc = 9'd228;
    logic [7:0] bg_color = 8'h00;
    logic [7:0] vga_data;

    int n_checks = 0;
    int n_pass   = 0;

    pacman_graphics dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .hc          (hc),
        .vc          (vc),
        .switches    (switches),
        .pacman_xloc (pacman_xloc),
        .pacman_yloc (pacman_yloc),
        .bg_color    (bg_color),
        .vga_data    (vga_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    endtask

    // Present one pixel for one clock, then compare the registered colour.
    task automatic pixel(input string tag, input int h, input int v, input logic [7:0] exp);
        @(negedge clk);
        hc = 10'(h);
        vc = 10'(v);
        @(posedge clk);
        #1;
        check(tag, vga_data, exp);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hc = 10'd799;
            vc = 10'd524;
        end
        @(negedge clk);
        hc = 10'd0;
        vc = 10'd0;
    endtask

    initial begin
        // Reset state
        #2 rst = 1'b0;
        #1 check("reset_out", vga_data, 8'h00);
        @(negedge clk);
        rst = 1'b1;

        // Main colour function
        pixel("pac_centre",   328, 344, 8'hFC);
        pixel("wall_tl",      208, 116, 8'h03);
        pixel("path_11",      219, 127, 8'h00);
        bg_color = 8'h24;
        pixel("path_11_bg",   219, 127, 8'h24);
        pixel("tunnel_row",   208, 228, 8'h24);
        bg_color = 8'h00;

        // Blanking and playfield edges
        pixel("hblank",       700, 200, 8'h00);
        pixel("vblank",       300, 500, 8'h00);
        pixel("out_range",    900, 530, 8'h00);
        pixel("outside_pf",   100, 200, 8'h00);
        pixel("pf_left_m1",   207, 120, 8'h00);
        pixel("pf_right",     431, 116, 8'h03);
        pixel("pf_right_p1",  432, 116, 8'h00);
        pixel("pf_bottom",    208, 363, 8'h03);
        pixel("pf_bottom_p1", 208, 364, 8'h00);

        // Disc edge, mouth closed: 36+4 inside, 36+9 outside (wall tile)
        pixel("disc_r2_40",   322, 342, 8'hFC);
        pixel("disc_r2_45",   322, 341, 8'h03);

        // Position inputs take effect immediately
        pacman_xloc = 9'd12;
        pacman_yloc = 9'd12;
        pixel("moved_pac",    220, 128, 8'hFC);
        pacman_xloc = 9'd120;
        pacman_yloc = 9'd228;

        // Animation
        pixel("mouth_f0",     333, 345, 8'hFC);
        frames(7);
        pixel("mouth_f7",     333, 345, 8'hFC);
        frames(1);
        pixel("mouth_f8",     333, 345, 8'h00);
        pixel("wedge_diag",   332, 348, 8'h00);
        pixel("wedge_out",    331, 348, 8'hFC);
        pixel("wedge_left",   323, 344, 8'hFC);
        btn = 1'b0;
        frames(8);
        pixel("paused",       333, 345, 8'h00);
        btn = 1'b1;
        frames(8);
        pixel("wrap_f0",      333, 345, 8'hFC);
        frames(8);
        pixel("reopen_f8",    333, 345, 8'h00);

        // Mid-line reset
        pixel("pre_reset",    328, 344, 8'hFC);
        #2 rst = 1'b0;
        #1 check("rst_async", vga_data, 8'h00);
        @(posedge clk);
        #1 check("rst_hold", vga_data, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        pixel("rst_frame0",   333, 345, 8'hFC);

        // Debug controls
`ifdef GRAPHICS_DEBUG_EN
        switches = 10'b01;
        pixel("dbg_pattern",  168, 96,  8'hAD);
        pixel("dbg_blank",    700, 96,  8'h00);
        switches = 10'b10;
        pixel("dbg_grid",     208, 116, 8'hFF);
        pixel("dbg_grid_pac", 328, 344, 8'hFC);
        pixel("dbg_nogrid",   219, 127, 8'h00);
`else
        switches = 10'b11;
        pixel("sw_ignored_a", 168, 96,  8'h00);
        pixel("sw_ignored_b", 208, 116, 8'h03);
`endif
        switches = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
